// File: rtl/pe_ctrl_pkg.sv
// Shared state type, OPMODE words and mux-select codes for the PE_NOCASC sequencer.
package pe_ctrl_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StFetchA,
      StT0,
      StWaitT0,
      StMq,
      StWaitMq,
      StInner,
      StDrain,
      StDone
   } pe_ctrl_state_t;

   localparam logic [6:0] OP_ZERO = 7'b0000000;
   localparam logic [6:0] OP_MUL  = 7'b0000101;
   localparam logic [6:0] OP_MULC = 7'b0110101;

   localparam logic [1:0] SEL_A_AREG   = 2'd0;
   localparam logic [1:0] SEL_A_RES    = 2'd1;
   localparam logic [1:0] SEL_A_MREG   = 2'd2;
   localparam logic [1:0] SEL_B_B      = 2'd0;
   localparam logic [1:0] SEL_B_PPRIME = 2'd1;
   localparam logic [1:0] SEL_B_P      = 2'd2;
   localparam logic [1:0] SEL_C_CIN    = 2'd0;
   localparam logic [1:0] SEL_C_RESDLY = 2'd1;

   // A one-word operand still needs a 1-bit index signal.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_ctrl_loop_cnt.sv
// Loop counter with synchronous clear/increment, look-ahead value and terminal flag.
module pe_ctrl_loop_cnt #(
   parameter int unsigned Width = 2,
   parameter int unsigned Max   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [Width-1:0] cnt_nxt,
   output logic             last
);

   localparam logic [Width-1:0] MaxV = Width'(Max);

   logic [Width-1:0] cnt_q;

   always_comb begin
      cnt_nxt = cnt_q;
      if (clr) begin
         cnt_nxt = '0;
      end else if (en) begin
         cnt_nxt = cnt_q + 1'b1;
      end
   end

   assign last = (cnt_q == MaxV);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pe_nocasc_ctrl.sv
// FIOS Montgomery sequencer for one PE_NOCASC row; all outputs registered.
// Optional cycle counter output enabled by defining PE_CTRL_PERF_CNT_EN.
module pe_nocasc_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned S     = 4,
   parameter int unsigned ABREG = 1,
   parameter int unsigned MREG  = 1
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [clog2_min1(S)-1:0]   a_addr_o,
   output logic [clog2_min1(S)-1:0]   bp_addr_o,
   output logic                       a_reg_en_o,
   output logic                       m_reg_en_o,
   output logic [1:0]                 mux_A_sel_o,
   output logic [1:0]                 mux_B_sel_o,
   output logic [1:0]                 mux_C_sel_o,
   output logic                       CREG_en_o,
   output logic [6:0]                 OPMODE_o,
   output logic                       RES_delay_en_o
`ifdef PE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                cycle_cnt_o
`endif
);

   localparam int unsigned L  = 1 + ABREG + MREG;
   localparam int unsigned AW = clog2_min1(S);
   localparam int unsigned WW = clog2_min1(L);
   localparam logic [WW-1:0] LAST_W = WW'(L - 1);

   pe_ctrl_state_t state_q, state_d;
   logic           ph_q, ph_d;

   logic          i_clr, i_en, i_last;
   logic [AW-1:0] i_nxt;
   logic          j_clr, j_en, j_last;
   logic [AW-1:0] j_nxt;
   logic          w_clr, w_en, w_last;
   logic [WW-1:0] w_nxt;
   logic          in_wait;

   pe_ctrl_loop_cnt #(.Width(AW), .Max(S - 1)) u_i_cnt (
      .clk     (clock_i),
      .rst     (reset_i),
      .clr     (i_clr),
      .en      (i_en),
      .cnt_nxt (i_nxt),
      .last    (i_last)
   );

   pe_ctrl_loop_cnt #(.Width(AW), .Max(S - 1)) u_j_cnt (
      .clk     (clock_i),
      .rst     (reset_i),
      .clr     (j_clr),
      .en      (j_en),
      .cnt_nxt (j_nxt),
      .last    (j_last)
   );

   pe_ctrl_loop_cnt #(.Width(WW), .Max(L - 1)) u_w_cnt (
      .clk     (clock_i),
      .rst     (reset_i),
      .clr     (w_clr),
      .en      (w_en),
      .cnt_nxt (w_nxt),
      .last    (w_last)
   );

   assign in_wait = state_q inside {StWaitT0, StWaitMq, StDrain};
   assign w_clr   = !in_wait || w_last;
   assign w_en    = in_wait;
   assign j_clr   = (state_q != StInner);
   // j advances after the m*p_j half of each pair.
   assign j_en    = (state_q == StInner) && ph_q && !j_last;
   assign i_clr   = state_q inside {StIdle, StDone};
   assign i_en    = (state_q == StDrain) && w_last && !i_last;

   always_comb begin
      state_d = state_q;
      ph_d    = 1'b0;
      unique case (state_q)
         StIdle:   if (start_i) state_d = StFetchA;
         StFetchA: state_d = StT0;
         StT0:     state_d = StWaitT0;
         StWaitT0: if (w_last) state_d = StMq;
         StMq:     state_d = StWaitMq;
         StWaitMq: if (w_last) state_d = StInner;
         StInner: begin
            ph_d = ~ph_q;
            if (ph_q && j_last) state_d = StDrain;
         end
         StDrain:  if (w_last) state_d = i_last ? StDone : StFetchA;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q        <= StIdle;
         ph_q           <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         a_addr_o       <= '0;
         bp_addr_o      <= '0;
         a_reg_en_o     <= 1'b0;
         m_reg_en_o     <= 1'b0;
         mux_A_sel_o    <= SEL_A_AREG;
         mux_B_sel_o    <= SEL_B_B;
         mux_C_sel_o    <= SEL_C_CIN;
         CREG_en_o      <= 1'b0;
         OPMODE_o       <= OP_ZERO;
         RES_delay_en_o <= 1'b0;
      end else begin
         state_q        <= state_d;
         ph_q           <= ph_d;
         busy_o         <= (state_d != StIdle);
         done_o         <= (state_d == StDone);
         a_addr_o       <= i_nxt;
         bp_addr_o      <= j_nxt;
         a_reg_en_o     <= (state_d == StFetchA);
         m_reg_en_o     <= (state_d == StWaitMq) && (w_nxt == LAST_W);
         mux_A_sel_o    <= SEL_A_AREG;
         mux_B_sel_o    <= SEL_B_B;
         mux_C_sel_o    <= SEL_C_CIN;
         CREG_en_o      <= 1'b0;
         OPMODE_o       <= OP_ZERO;
         RES_delay_en_o <= 1'b0;
         case (state_d)
            StT0: begin
               if (i_nxt == '0) begin
                  OPMODE_o <= OP_MUL;
               end else begin
                  OPMODE_o    <= OP_MULC;
                  mux_C_sel_o <= SEL_C_RESDLY;
               end
            end
            StMq: begin
               mux_A_sel_o <= SEL_A_RES;
               mux_B_sel_o <= SEL_B_PPRIME;
               OPMODE_o    <= OP_MUL;
            end
            StInner: begin
               CREG_en_o   <= 1'b1;
               mux_C_sel_o <= SEL_C_RESDLY;
               OPMODE_o    <= OP_MULC;
               if (ph_d) begin
                  mux_A_sel_o    <= SEL_A_MREG;
                  mux_B_sel_o    <= SEL_B_P;
                  RES_delay_en_o <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PE_CTRL_PERF_CNT_EN
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cycle_cnt_o <= '0;
      end else if ((state_q == StIdle) && start_i) begin
         cycle_cnt_o <= '0;
      end else if (busy_o) begin
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_nocasc_ctrl.sv
// Scoreboard bench for pe_nocasc_ctrl at S=4, L=3: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pe_nocasc_ctrl;

   localparam logic [6:0] OpMul  = 7'b0000101;
   localparam logic [6:0] OpMulc = 7'b0110101;

   logic       clock;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] a_addr;
   logic [1:0] bp_addr;
   logic       a_reg_en;
   logic       m_reg_en;
   logic [1:0] a_sel;
   logic [1:0] b_sel;
   logic [1:0] c_sel;
   logic       creg_en;
   logic [6:0] opmode;
   logic       res_dly_en;
`ifdef PE_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt;
`endif

   int cyc = 0;
   int n_vec = 0;
   int n_miss = 0;
   bit expect_idle = 1'b0;

   int          exp_done[$];
   int          exp_mreg[$];
   logic [1:0]  exp_fetch[$];
   logic [10:0] exp_t0[$];
   logic [15:0] exp_inner[$];

   logic [10:0] t0_tab[4];
   logic [15:0] inner_tab[8];
   int          mreg_off[4];

   pe_nocasc_ctrl #(
      .S     (4),
      .ABREG (1),
      .MREG  (1)
   ) dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .start_i        (start),
      .busy_o         (busy),
      .done_o         (done),
      .a_addr_o       (a_addr),
      .bp_addr_o      (bp_addr),
      .a_reg_en_o     (a_reg_en),
      .m_reg_en_o     (m_reg_en),
      .mux_A_sel_o    (a_sel),
      .mux_B_sel_o    (b_sel),
      .mux_C_sel_o    (c_sel),
      .CREG_en_o      (creg_en),
      .OPMODE_o       (opmode),
      .RES_delay_en_o (res_dly_en)
`ifdef PE_CTRL_PERF_CNT_EN
      ,
      .cycle_cnt_o    (cycle_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: event seen in cycle %0d, none required", name, cyc);
   endtask

   // Monitor: every DUT event pops the matching expectation.
   always @(negedge clock) begin
      if (expect_idle) begin
         check("idle_outputs", 32'({busy, done, a_addr, bp_addr, a_reg_en, m_reg_en, a_sel,
                                   b_sel, c_sel, creg_en, opmode, res_dly_en}), 32'd0);
      end
      if (done === 1'b1) begin
         if (exp_done.size() == 0) unexpected("done_o");
         else check("done_cycle", cyc, exp_done.pop_front());
      end
      if (m_reg_en === 1'b1) begin
         if (exp_mreg.size() == 0) unexpected("m_reg_en");
         else check("m_reg_en_cycle", cyc, exp_mreg.pop_front());
      end
      if (a_reg_en === 1'b1) begin
         if (exp_fetch.size() == 0) unexpected("a_reg_en");
         else check("fetch_a_addr", 32'(a_addr), 32'(exp_fetch.pop_front()));
      end
      if (creg_en === 1'b1) begin
         if (exp_inner.size() == 0) unexpected("inner_cycle");
         else check("inner_ctrl", 32'({bp_addr, a_sel, b_sel, c_sel, res_dly_en, opmode}),
                    32'(exp_inner.pop_front()));
      end
      if (creg_en === 1'b0 && a_sel === 2'd0 && opmode !== 7'd0) begin
         if (exp_t0.size() == 0) unexpected("t0_cycle");
         else check("t0_ctrl", 32'({a_addr, opmode, c_sel}), 32'(exp_t0.pop_front()));
      end
   end

   task automatic push_op(input int acc);
      exp_done.push_back(acc + 81);
      for (int i = 0; i < 4; i++) begin
         exp_fetch.push_back(2'(i));
         exp_t0.push_back(t0_tab[i]);
         exp_mreg.push_back(acc + mreg_off[i]);
         for (int k = 0; k < 8; k++) exp_inner.push_back(inner_tab[k]);
      end
   endtask

   task automatic flush();
      exp_done.delete();
      exp_mreg.delete();
      exp_fetch.delete();
      exp_t0.delete();
      exp_inner.delete();
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_done_left(input int left, input int budget);
      int n;
      n = 0;
      while (exp_done.size() > left && n < budget) begin
         step(1);
         n++;
      end
      if (exp_done.size() > left) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout: %0d done pulses outstanding, required %0d", exp_done.size(),
                  left);
         flush();
      end
   endtask

   task automatic idle_window(input int n);
      expect_idle = 1'b1;
      step(n);
      expect_idle = 1'b0;
   endtask

   task automatic run_single_op();
      start = 1'b1;
      push_op(cyc);
      step(1);
      start = 1'b0;
      wait_done_left(0, 200);
      idle_window(2);
   endtask

   initial begin
      int c;
      int n;
      t0_tab[0] = {2'd0, OpMul,  2'd0};
      t0_tab[1] = {2'd1, OpMulc, 2'd1};
      t0_tab[2] = {2'd2, OpMulc, 2'd1};
      t0_tab[3] = {2'd3, OpMulc, 2'd1};
      inner_tab[0] = {2'd0, 2'd0, 2'd0, 2'd1, 1'b0, OpMulc};
      inner_tab[1] = {2'd0, 2'd2, 2'd2, 2'd1, 1'b1, OpMulc};
      inner_tab[2] = {2'd1, 2'd0, 2'd0, 2'd1, 1'b0, OpMulc};
      inner_tab[3] = {2'd1, 2'd2, 2'd2, 2'd1, 1'b1, OpMulc};
      inner_tab[4] = {2'd2, 2'd0, 2'd0, 2'd1, 1'b0, OpMulc};
      inner_tab[5] = {2'd2, 2'd2, 2'd2, 2'd1, 1'b1, OpMulc};
      inner_tab[6] = {2'd3, 2'd0, 2'd0, 2'd1, 1'b0, OpMulc};
      inner_tab[7] = {2'd3, 2'd2, 2'd2, 2'd1, 1'b1, OpMulc};
      mreg_off[0] = 9;
      mreg_off[1] = 29;
      mreg_off[2] = 49;
      mreg_off[3] = 69;

      // Reset, then idle with start low.
      reset = 1'b1;
      start = 1'b0;
      step(1);
      expect_idle = 1'b1;
      step(2);
      reset = 1'b0;
      step(10);
      expect_idle = 1'b0;

      run_single_op();

      // start held high: one done, then restart on the following idle cycle.
      start = 1'b1;
      c = cyc;
      push_op(c);
      push_op(c + 82);
      wait_done_left(1, 200);
      step(1);
      start = 1'b0;
      wait_done_left(0, 200);
      idle_window(2);

      // Reset during the first INNER cycle of iteration i=2.
      start = 1'b1;
      push_op(cyc);
      step(1);
      start = 1'b0;
      n = 0;
      while (!(a_addr === 2'd2 && creg_en === 1'b1) && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) begin
         n_vec++;
         n_miss++;
         $display("FAIL inner_i2_timeout: INNER of i=2 not reached, required within 200 cycles");
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      flush();
      idle_window(3);

      run_single_op();

      check("leftover_done", 32'(exp_done.size()), 32'd0);
      check("leftover_mreg", 32'(exp_mreg.size()), 32'd0);
      check("leftover_fetch", 32'(exp_fetch.size()), 32'd0);
      check("leftover_t0", 32'(exp_t0.size()), 32'd0);
      check("leftover_inner", 32'(exp_inner.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required to end", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pe_nocasc_ctrl.md
Name: pe_nocasc_ctrl

Overview:
- Sequencer for one PE_NOCASC processing element running FIOS Montgomery multiplication on S 17-bit words.
- Drives every PE control input: a_reg_en, m_reg_en, mux A/B/C selects, CREG_en, OPMODE, RES_delay_en.
- Generates word addresses for the a, b and p operand memories.
- Sits between the top-level multiplier FSM (start/done handshake) and the PE; one instance per PE row.

Parameters:
S, 4, number of 17-bit words per operand (1..64)
ABREG, 1, DSP A/B register depth of the driven PE (0 or 1)
MREG, 1, DSP M register depth of the driven PE (0 or 1)
L (localparam), 1+ABREG+MREG, DSP result latency in cycles, counted from PE control-input registration

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  start one multiplication; sampled only in IDLE
busy_o  out  1  high from the cycle after start is accepted until done_o
done_o  out  1  one-cycle pulse when the last result word has drained
a_addr_o  out  $clog2(S)  word index i of a
bp_addr_o  out  $clog2(S)  word index j for b and p memories
a_reg_en_o  out  1  to PE a_reg_en_i
m_reg_en_o  out  1  to PE m_reg_en_i
mux_A_sel_o  out  2  0=a_reg, 1=RES, 2=m_reg
mux_B_sel_o  out  2  0=b, 1=p_prime_0, 2=p
mux_C_sel_o  out  2  0=C_i, 1=RES_delay, 2/3=delayed C inputs
CREG_en_o  out  1  to PE CREG_en_i
OPMODE_o  out  7  to PE OPMODE_i
RES_delay_en_o  out  1  to PE RES_delay_en_i

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- All outputs are registered. Reset value of every output is 0: OPMODE_o=OP_ZERO, addresses 0, busy_o=0, done_o=0.
- Reset mid-operation aborts immediately: next state IDLE, counters cleared.
- FSM states: IDLE, FETCH_A, T0, WAIT_T0, MQ, WAIT_MQ, INNER, DRAIN, DONE.
- IDLE: start_i=1 -> FETCH_A; i=0; busy_o=1 from next cycle.
- FETCH_A, 1 cycle: a_reg_en_o=1; a_addr_o=i.
- T0, 1 cycle:
  - A sel=0, B sel=0, bp_addr_o=0.
  - i==0: OPMODE=OP_MUL. i>0: OPMODE=OP_MULC with C sel=1 (accumulate previous partial sum).
- WAIT_T0: L cycles, wait counter w; OPMODE=OP_ZERO.
- MQ, 1 cycle: A sel=1 (RES = t0 low), B sel=1, OPMODE=OP_MUL; computes m = t0*p'0 mod 2^17.
- WAIT_MQ: L cycles. m_reg_en_o=1 on the final cycle only, so m_reg captures m.
- INNER: 2S cycles, j = 0..S-1, two cycles per j:
  - Even cycle: A sel=0, B sel=0 (a_i*b_j), C sel=1, OPMODE=OP_MULC.
  - Odd cycle: A sel=2, B sel=2 (m*p_j), C sel=1, OPMODE=OP_MULC.
  - RES_delay_en_o=1 on odd cycles; CREG_en_o=1 on every INNER cycle.
  - bp_addr_o=j.
- DRAIN: L cycles with OPMODE=OP_ZERO.
  - i<S-1: i++ and return to FETCH_A.
  - else -> DONE.
- DONE, 1 cycle: done_o=1, busy_o=0 next cycle, -> IDLE.
- Cycles per outer iteration: 2S+3+3L. Total from start acceptance to done_o: S*(2S+3+3L)+1.
- start_i while busy is ignored. start_i in the DONE cycle is ignored.
- S=1 is legal: INNER lasts 2 cycles.
- Counters i, j are $clog2(S) bits wide and never wrap during an operation. The state transition occurs on the terminal value S-1.

Optional Feature:
- Macro: PE_CTRL_PERF_CNT_EN.
- Defined: adds output cycle_cnt_o [31:0]. It clears on start acceptance, increments every busy cycle and holds its value after done_o; reset value 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package pe_ctrl_pkg holds:
  - state enum pe_ctrl_state_t.
  - OPMODE constants: OP_ZERO=7'b0000000, OP_MUL=7'b0000101, OP_MULC=7'b0110101.
  - mux select constants: SEL_A_AREG/RES/MREG, SEL_B_B/PPRIME/P, SEL_C_CIN/RESDLY.
- Sub-module pe_ctrl_loop_cnt: reusable load/enable/terminal-flag counter, instanced for i, j and w.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; start_i=0 -> busy_o stays 0.
- S=4, ABREG=MREG=1 (L=3), start pulse -> done_o exactly 81 cycles after acceptance; a_addr_o steps 0,1,2,3; OPMODE in T0 is OP_MUL for i=0, OP_MULC for i>0.
- Inner sequence for S=4: bp_addr_o = 0,0,1,1,2,2,3,3; mux_A_sel_o alternates 0,2; RES_delay_en_o high only on odd INNER cycles.
- m_reg_en_o: exactly one pulse per outer iteration, on the last WAIT_MQ cycle (4 pulses for S=4).
- start_i held high through the whole operation -> a single done_o pulse, then a restart on the following IDLE cycle.
- reset_i asserted in INNER of iteration i=2 -> next cycle in IDLE, all outputs 0, no done_o; a fresh start completes normally in 81 cycles.
